// File: rtl/bp_btb_predictor.sv
// +----------------------------------------------------------------------------+
// | Module      : bp_btb_predictor                                             |
// | Description : Direct-mapped tagged BTB with 2-bit direction counters.      |
// |               Optional gshare direction PHT enabled by BP_GSHARE_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bp_btb_predictor #(
    parameter int ENTRIES   = 32,
    parameter int TAG_BITS  = 8,
    parameter int HIST_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_addr,
    input  logic        id_stall,
    input  logic        wb_flush,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_target,
    input  logic        ex_target_valid,
    input  logic        ex_br_inst,
    input  logic        ex_is_uncond,
    input  logic        ex_br_taken,
    output logic [31:0] id_target,
    output logic        id_target_taken
);

    localparam int IDX = $clog2(ENTRIES);

    if (ENTRIES < 2 || ENTRIES > 256 || (1 << IDX) != ENTRIES ||
        TAG_BITS < 1 || TAG_BITS > 30 - IDX || HIST_BITS < 1 || HIST_BITS > IDX) begin : g_bad_params
        $error("bp_btb_predictor: illegal parameter combination");
    end

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [IDX-1:0]      if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit, upd, alloc, dir_taken;
    logic [1:0]          alloc_ctr;
    logic                unused_addr_bits;

    assign if_idx = if_addr[IDX+1:2];
    assign ex_idx = ex_addr[IDX+1:2];
    assign if_tag = if_addr[IDX+TAG_BITS+1:IDX+2];
    assign ex_tag = ex_addr[IDX+TAG_BITS+1:IDX+2];
    assign unused_addr_bits = ^{if_addr, ex_addr};

    assign if_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign upd       = ex_br_inst && !id_stall && !wb_flush;
    assign alloc     = !ex_hit && ex_br_taken && ex_target_valid;
    assign alloc_ctr = ex_is_uncond ? 2'b11 : 2'b10;

    function automatic logic [1:0] ctr_train(input logic [1:0] c, input logic uncond,
                                             input logic taken);
        if (uncond) return 2'b11;
        if (taken)  return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Tag/target storage carries no reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd) begin
            if (ex_hit) begin
                if (ex_br_taken && ex_target_valid) target_q[ex_idx] <= ex_target;
            end else if (alloc) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
            end
        end
    end

`ifdef BP_GSHARE_EN
    logic [1:0]           pht_q [ENTRIES];
    logic [HIST_BITS-1:0] ghr_q;
    logic [IDX-1:0]       ghr_ext, if_pht_idx, ex_pht_idx;

    always_comb begin
        ghr_ext                  = '0;
        ghr_ext[HIST_BITS-1:0]   = ghr_q;
    end

    assign if_pht_idx = if_idx ^ ghr_ext;
    assign ex_pht_idx = ex_idx ^ ghr_ext;
    assign dir_taken  = pht_q[if_pht_idx][1];

    // Training indexes with the pre-shift history; the shift lands the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b00;
        end else if (upd) begin
            if (!ex_is_uncond) ghr_q <= HIST_BITS'({ghr_q, ex_br_taken});
            if (ex_hit)
                pht_q[ex_pht_idx] <= ctr_train(pht_q[ex_pht_idx], ex_is_uncond, ex_br_taken);
            else if (alloc)
                pht_q[ex_pht_idx] <= alloc_ctr;
        end
    end
`else
    logic [1:0] ctr_q [ENTRIES];

    assign dir_taken = ctr_q[if_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
        end else if (upd) begin
            if (ex_hit)
                ctr_q[ex_idx] <= ctr_train(ctr_q[ex_idx], ex_is_uncond, ex_br_taken);
            else if (alloc)
                ctr_q[ex_idx] <= alloc_ctr;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            id_target       <= '0;
            id_target_taken <= 1'b0;
        end else if (wb_flush) begin
            id_target_taken <= 1'b0;
        end else if (!id_stall) begin
            id_target       <= target_q[if_idx];
            id_target_taken <= if_hit && dir_taken;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_btb_predictor.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_bp_btb_predictor                                          |
// | Description : Directed self-checking bench for bp_btb_predictor (default). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bp_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_addr;
    logic        id_stall;
    logic        wb_flush;
    logic [31:0] ex_addr;
    logic [31:0] ex_target;
    logic        ex_target_valid;
    logic        ex_br_inst;
    logic        ex_is_uncond;
    logic        ex_br_taken;
    logic [31:0] id_target;
    logic        id_target_taken;

    int checks   = 0;
    int failures = 0;

    bp_btb_predictor #(.ENTRIES(32), .TAG_BITS(8), .HIST_BITS(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_addr         (if_addr),
        .id_stall        (id_stall),
        .wb_flush        (wb_flush),
        .ex_addr         (ex_addr),
        .ex_target       (ex_target),
        .ex_target_valid (ex_target_valid),
        .ex_br_inst      (ex_br_inst),
        .ex_is_uncond    (ex_is_uncond),
        .ex_br_taken     (ex_br_taken),
        .id_target       (id_target),
        .id_target_taken (id_target_taken)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a);
        if_addr = a;
        tick();
    endtask

    task automatic train(input logic [31:0] a, input logic [31:0] t, input logic taken,
                         input logic uncond, input logic tvalid);
        ex_addr         = a;
        ex_target       = t;
        ex_br_taken     = taken;
        ex_is_uncond    = uncond;
        ex_target_valid = tvalid;
        ex_br_inst      = 1'b1;
        tick();
        ex_br_inst      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_addr = 32'h4000_0010;
        tick();
        tick();
        checks++;
        if (id_target !== 32'h0) begin
            $display("FAIL reset_target: got %h expected %h", id_target, 32'h0);
            failures++;
        end
        rst = 1'b0;
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL reset_lookup_taken: got %b expected 0", id_target_taken);
            failures++;
        end
    endtask

    task automatic test_train_taken();
        train(32'h4000_0010, 32'h4000_0100, 1'b1, 1'b0, 1'b1);
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b1) begin
            $display("FAIL alloc_taken: got %b expected 1", id_target_taken);
            failures++;
        end
        checks++;
        if (id_target !== 32'h4000_0100) begin
            $display("FAIL alloc_target: got %h expected %h", id_target, 32'h4000_0100);
            failures++;
        end
    endtask

    // Counter walk from 2: NT->1, NT->0, NT->0, T->1, T->2, T->3, T->3, NT->2, NT->1.
    task automatic test_counter();
        train(32'h4000_0010, 32'h0, 1'b0, 1'b0, 1'b1);
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL ctr_2to1: got %b expected 0", id_target_taken);
            failures++;
        end
        train(32'h4000_0010, 32'h0, 1'b0, 1'b0, 1'b1);
        train(32'h4000_0010, 32'h0, 1'b0, 1'b0, 1'b1);
        train(32'h4000_0010, 32'h4000_0100, 1'b1, 1'b0, 1'b1);
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL ctr_floor_then_inc: got %b expected 0", id_target_taken);
            failures++;
        end
        train(32'h4000_0010, 32'h4000_0100, 1'b1, 1'b0, 1'b1);
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b1) begin
            $display("FAIL ctr_1to2: got %b expected 1", id_target_taken);
            failures++;
        end
        train(32'h4000_0010, 32'h4000_0100, 1'b1, 1'b0, 1'b1);
        train(32'h4000_0010, 32'h4000_0100, 1'b1, 1'b0, 1'b1);
        train(32'h4000_0010, 32'h0, 1'b0, 1'b0, 1'b1);
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b1) begin
            $display("FAIL ctr_ceiling: got %b expected 1", id_target_taken);
            failures++;
        end
        train(32'h4000_0010, 32'h0, 1'b0, 1'b0, 1'b1);
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL ctr_2to1_again: got %b expected 0", id_target_taken);
            failures++;
        end
        checks++;
        if (id_target !== 32'h4000_0100) begin
            $display("FAIL ctr_target_kept: got %h expected %h", id_target, 32'h4000_0100);
            failures++;
        end
    endtask

    task automatic test_uncond();
        train(32'h4000_0020, 32'h4000_0400, 1'b1, 1'b1, 1'b1);
        train(32'h4000_0020, 32'h0, 1'b0, 1'b0, 1'b1);
        lookup(32'h4000_0020);
        checks++;
        if (id_target_taken !== 1'b1) begin
            $display("FAIL uncond_alloc_init: got %b expected 1", id_target_taken);
            failures++;
        end
        train(32'h4000_0020, 32'h0, 1'b0, 1'b0, 1'b1);
        train(32'h4000_0020, 32'h4000_0440, 1'b1, 1'b1, 1'b1);
        train(32'h4000_0020, 32'h0, 1'b0, 1'b0, 1'b1);
        lookup(32'h4000_0020);
        checks++;
        if (id_target_taken !== 1'b1) begin
            $display("FAIL uncond_hit_sets3: got %b expected 1", id_target_taken);
            failures++;
        end
        train(32'h4000_0020, 32'h0000_0999, 1'b1, 1'b0, 1'b0);
        lookup(32'h4000_0020);
        checks++;
        if (id_target !== 32'h4000_0440) begin
            $display("FAIL target_update_gated: got %h expected %h", id_target, 32'h4000_0440);
            failures++;
        end
        train(32'h4000_0030, 32'h4000_0300, 1'b0, 1'b0, 1'b1);
        lookup(32'h4000_0030);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL nt_miss_no_alloc: got %b expected 0", id_target_taken);
            failures++;
        end
    endtask

    task automatic test_alias();
        train(32'h4000_0010, 32'h4000_0100, 1'b1, 1'b0, 1'b1);
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b1) begin
            $display("FAIL alias_pre: got %b expected 1", id_target_taken);
            failures++;
        end
        train(32'h4000_0090, 32'h4000_0900, 1'b1, 1'b0, 1'b1);
        lookup(32'h4000_0010);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL alias_old_miss: got %b expected 0", id_target_taken);
            failures++;
        end
        lookup(32'h4000_0090);
        checks++;
        if (id_target_taken !== 1'b1 || id_target !== 32'h4000_0900) begin
            $display("FAIL alias_new_hit: got %b/%h expected 1/%h", id_target_taken, id_target,
                     32'h4000_0900);
            failures++;
        end
    endtask

    task automatic test_stall();
        train(32'h4000_0040, 32'h4000_0800, 1'b1, 1'b0, 1'b1);
        train(32'h4000_0040, 32'h0, 1'b0, 1'b0, 1'b1);
        train(32'h4000_0040, 32'h0, 1'b0, 1'b0, 1'b1);
        lookup(32'h4000_0090);
        ex_addr = 32'h4000_0040; ex_target = 32'h4000_0800;
        ex_br_taken = 1'b1; ex_is_uncond = 1'b0; ex_target_valid = 1'b1;
        ex_br_inst = 1'b1; id_stall = 1'b1;
        if_addr = 32'h4000_0040;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (id_target_taken !== 1'b1 || id_target !== 32'h4000_0900) begin
            $display("FAIL stall_hold: got %b/%h expected 1/%h", id_target_taken, id_target,
                     32'h4000_0900);
            failures++;
        end
        id_stall = 1'b0;
        tick();
        ex_br_inst = 1'b0;
        lookup(32'h4000_0040);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL stall_single_inc: got %b expected 0", id_target_taken);
            failures++;
        end
        train(32'h4000_0040, 32'h4000_0800, 1'b1, 1'b0, 1'b1);
        lookup(32'h4000_0040);
        checks++;
        if (id_target_taken !== 1'b1) begin
            $display("FAIL stall_then_inc: got %b expected 1", id_target_taken);
            failures++;
        end
    endtask

    task automatic test_flush();
        lookup(32'h4000_0090);
        wb_flush = 1'b1;
        if_addr  = 32'h4000_0020;
        train(32'h4000_0200, 32'h4000_2000, 1'b1, 1'b0, 1'b1);
        checks++;
        if (id_target_taken !== 1'b0 || id_target !== 32'h4000_0900) begin
            $display("FAIL flush_output: got %b/%h expected 0/%h", id_target_taken, id_target,
                     32'h4000_0900);
            failures++;
        end
        train(32'h4000_0040, 32'h0, 1'b0, 1'b0, 1'b1);
        wb_flush = 1'b0;
        lookup(32'h4000_0200);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL flush_no_alloc: got %b expected 0", id_target_taken);
            failures++;
        end
        lookup(32'h4000_0040);
        checks++;
        if (id_target_taken !== 1'b1) begin
            $display("FAIL flush_no_ctr_update: got %b expected 1", id_target_taken);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        if_addr = 32'h4000_0050;
        train(32'h4000_0050, 32'h4000_0500, 1'b1, 1'b0, 1'b1);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL no_bypass: got %b expected 0", id_target_taken);
            failures++;
        end
        lookup(32'h4000_0050);
        checks++;
        if (id_target_taken !== 1'b1 || id_target !== 32'h4000_0500) begin
            $display("FAIL b2b_hit: got %b/%h expected 1/%h", id_target_taken, id_target,
                     32'h4000_0500);
            failures++;
        end
    endtask

    task automatic test_reset_mid_train();
        rst = 1'b1;
        train(32'h4000_0090, 32'h4000_0900, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        checks++;
        if (id_target_taken !== 1'b0 || id_target !== 32'h0) begin
            $display("FAIL rst_outputs: got %b/%h expected 0/0", id_target_taken, id_target);
            failures++;
        end
        lookup(32'h4000_0090);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL rst_invalidates_trained: got %b expected 0", id_target_taken);
            failures++;
        end
        lookup(32'h4000_0020);
        checks++;
        if (id_target_taken !== 1'b0) begin
            $display("FAIL rst_invalidates_other: got %b expected 0", id_target_taken);
            failures++;
        end
    endtask

    initial begin
        rst = 1'b1; if_addr = '0; id_stall = 1'b0; wb_flush = 1'b0;
        ex_addr = '0; ex_target = '0; ex_target_valid = 1'b0;
        ex_br_inst = 1'b0; ex_is_uncond = 1'b0; ex_br_taken = 1'b0;
        test_reset();
        test_train_taken();
        test_counter();
        test_uncond();
        test_alias();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_train();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
